// File: rtl/mcbsp_frame_slave.sv
// McBSP slave port oversampled in the a_clk domain: deserialises one frame into
// dataset_read and serialises a shadow copy of tx_dataset back to the master.
module mcbsp_frame_slave #(
  parameter int WORDS_PER_FRAME = 8,
  parameter int BITS_PER_WORD   = 32,
  parameter bit MSB_FIRST       = 1'b0,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                                     a_clk,
  input  logic                                     a_resetn,
  input  logic                                     mcbsp_clk,
  input  logic                                     mcbsp_frame_start,
  input  logic                                     mcbsp_data_rx,
  input  logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0] tx_dataset,
  output logic                                     mcbsp_data_tx,
  output logic                                     mcbsp_data_clkr,
  output logic                                     mcbsp_data_fsx,
  output logic                                     mcbsp_data_frm,
  output logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0] dataset_read,
  output logic                                     trigger,
  output logic                                     frame_error,
  output logic [31:0]                              frame_count,
  output logic [15:0]                              error_count
);
  localparam int N  = WORDS_PER_FRAME * BITS_PER_WORD;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Frame bit index -> register position; shared by RX capture and TX drive.
  function automatic logic [PW-1:0] bit_pos(input logic [CW-1:0] k);
    int kk;
    int w;
    int j;
    kk = int'(k);
    w  = kk / BITS_PER_WORD;
    j  = kk % BITS_PER_WORD;
    if (MSB_FIRST) begin
      bit_pos = PW'(w * BITS_PER_WORD + BITS_PER_WORD - 1 - j);
    end else begin
      bit_pos = PW'(kk);
    end
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r, fs_sync_r, rx_sync_r;
  logic                   clk_prev_r;
  logic                   clk_s, fs_s, rx_s, rise_s, fall_s;
  state_t                 state_r, state_nxt_s;
  logic                   start_s, shift_s, last_s, short_s;
  logic [CW-1:0]          cnt_r, tx_idx_r;
  logic                   tx_pend_r, done_r;
  logic [N-1:0]           rx_sr_r, shadow_r, dataset_r;
  logic                   trigger_r, frame_error_r;
  logic [31:0]            frame_count_r;
  logic [15:0]            error_count_r;
  logic                   tx_r, fsx_r, frm_r;

  assign clk_s  = clk_sync_r[SYNC_STAGES-1];
  assign fs_s   = fs_sync_r[SYNC_STAGES-1];
  assign rx_s   = rx_sync_r[SYNC_STAGES-1];
  assign rise_s = clk_s & ~clk_prev_r;
  assign fall_s = ~clk_s & clk_prev_r;

  // Input synchronisers and previous-clock register (also the clock return).
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      clk_sync_r <= '0;
      fs_sync_r  <= '0;
      rx_sync_r  <= '0;
      clk_prev_r <= 1'b0;
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], mcbsp_clk};
      fs_sync_r  <= {fs_sync_r[SYNC_STAGES-2:0], mcbsp_frame_start};
      rx_sync_r  <= {rx_sync_r[SYNC_STAGES-2:0], mcbsp_data_rx};
      clk_prev_r <= clk_s;
    end
  end

  // Frame state register.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; an FS during SHIFT is a short frame that restarts at once.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    shift_s     = 1'b0;
    last_s      = 1'b0;
    short_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s && fs_s) begin
          start_s     = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (rise_s && fs_s) begin
          start_s     = 1'b1;
          short_s     = 1'b1;
          state_nxt_s = SHIFT;
        end else if (rise_s) begin
          shift_s = 1'b1;
          if (cnt_r == LAST_BIT) begin
            last_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SHIFT;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // RX capture, TX shadow latch and frame/error bookkeeping.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      cnt_r         <= '0;
      tx_idx_r      <= '0;
      tx_pend_r     <= 1'b0;
      done_r        <= 1'b0;
      rx_sr_r       <= '0;
      shadow_r      <= '0;
      dataset_r     <= '0;
      trigger_r     <= 1'b0;
      frame_error_r <= 1'b0;
      frame_count_r <= 32'd0;
      error_count_r <= 16'd0;
    end else begin
      done_r        <= last_s;
      trigger_r     <= done_r;
      frame_error_r <= short_s;
      if (start_s) begin
        rx_sr_r                  <= '0;
        rx_sr_r[bit_pos(CW'(0))] <= rx_s;
        shadow_r                 <= tx_dataset;
        cnt_r                    <= CW'(1);
        tx_idx_r                 <= '0;
        tx_pend_r                <= 1'b1;
      end else if (shift_s) begin
        rx_sr_r[bit_pos(cnt_r)] <= rx_s;
        cnt_r                   <= cnt_r + CW'(1);
        tx_idx_r                <= cnt_r;
        tx_pend_r               <= 1'b1;
      end else if (fall_s) begin
        tx_pend_r <= 1'b0;
      end
      if (done_r) begin
        dataset_r     <= rx_sr_r;
        frame_count_r <= frame_count_r + 32'd1;
      end
      if (short_s && (error_count_r != 16'hFFFF)) begin
        error_count_r <= error_count_r + 16'd1;
      end
    end
  end

  // TX drive on falling edges: the bit captured last, or idle low.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      tx_r  <= 1'b0;
      fsx_r <= 1'b0;
      frm_r <= 1'b0;
    end else if (fall_s) begin
      if (tx_pend_r) begin
        tx_r  <= shadow_r[bit_pos(tx_idx_r)];
        fsx_r <= (tx_idx_r == CW'(0));
        frm_r <= 1'b1;
      end else begin
        tx_r  <= 1'b0;
        fsx_r <= 1'b0;
        frm_r <= 1'b0;
      end
    end
  end

  assign mcbsp_data_tx   = tx_r;
  assign mcbsp_data_clkr = clk_prev_r;
  assign mcbsp_data_fsx  = fsx_r;
  assign mcbsp_data_frm  = frm_r;
  assign dataset_read    = dataset_r;
  assign trigger         = trigger_r;
  assign frame_error     = frame_error_r;
  assign frame_count     = frame_count_r;
  assign error_count     = error_count_r;

endmodule

// File: tb/tb_mcbsp_frame_slave.sv
// Randomised bench for mcbsp_frame_slave: a bit-level McBSP master drives the
// DUTs and a frame-level model predicts dataset, counters and the TX stream.
module tb_mcbsp_frame_slave;
  localparam int N0 = 256;
  localparam int N1 = 64;

  logic a_clk = 1'b0;
  logic a_resetn = 1'b0;
  logic mclk = 1'b0;
  logic fs = 1'b0;
  logic rxd = 1'b0;
  logic sel = 1'b0;
  logic [N0-1:0] tx_dataset = '0;
  logic [N1-1:0] tx_dataset1 = '0;
  logic mclk0, mclk1;
  assign mclk0 = mclk & ~sel;
  assign mclk1 = mclk & sel;

  logic tx0, clkr0, fsx0, frm0, trigger0, frame_error0;
  logic [N0-1:0] dataset_read0;
  logic [31:0] frame_count0;
  logic [15:0] error_count0;
  logic tx1, clkr1, fsx1, frm1, trigger1, frame_error1;
  logic [N1-1:0] dataset_read1;
  logic [31:0] frame_count1;
  logic [15:0] error_count1;

  mcbsp_frame_slave dut0 (
    .a_clk(a_clk), .a_resetn(a_resetn), .mcbsp_clk(mclk0),
    .mcbsp_frame_start(fs), .mcbsp_data_rx(rxd), .tx_dataset(tx_dataset),
    .mcbsp_data_tx(tx0), .mcbsp_data_clkr(clkr0), .mcbsp_data_fsx(fsx0),
    .mcbsp_data_frm(frm0), .dataset_read(dataset_read0), .trigger(trigger0),
    .frame_error(frame_error0), .frame_count(frame_count0), .error_count(error_count0)
  );

  mcbsp_frame_slave #(.WORDS_PER_FRAME(4), .BITS_PER_WORD(16), .MSB_FIRST(1'b1)) dut1 (
    .a_clk(a_clk), .a_resetn(a_resetn), .mcbsp_clk(mclk1),
    .mcbsp_frame_start(fs), .mcbsp_data_rx(rxd), .tx_dataset(tx_dataset1),
    .mcbsp_data_tx(tx1), .mcbsp_data_clkr(clkr1), .mcbsp_data_fsx(fsx1),
    .mcbsp_data_frm(frm1), .dataset_read(dataset_read1), .trigger(trigger1),
    .frame_error(frame_error1), .frame_count(frame_count1), .error_count(error_count1)
  );

  always #5 a_clk = ~a_clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitors, sampled away from the active edge.
  int trig0 = 0, ferr0 = 0, trig1 = 0, coincide = 0;
  logic [N0-1:0] ds_at_trig = '0;
  always @(negedge a_clk) begin
    if (trigger0) begin trig0++; ds_at_trig = dataset_read0; end
    if (frame_error0) ferr0++;
    if (trigger1) trig1++;
    if (trigger0 && frame_error0) coincide++;
  end

  // Frame-level reference model.
  logic [N0-1:0] exp_ds0 = '0;
  logic [31:0]   exp_fc0 = 32'd0;
  logic [15:0]   exp_ec0 = 16'd0;
  int            exp_ferr0 = 0, exp_trig0 = 0;
  bit            in_frame = 1'b0;

  int hp = 12;
  int chg_at = -1;
  logic [N0-1:0] chg_val = '0;
  bit logging = 1'b0;
  logic txq[$];
  int fsx_n = 0, frm_n = 0;

  task automatic send_bit(input logic f, input logic d);
    fs = f;
    rxd = d;
    repeat (hp) @(negedge a_clk);
    if (logging) begin
      txq.push_back(tx0);
      fsx_n += int'(fsx0);
      frm_n += int'(frm0);
    end
    mclk = 1'b1;
    repeat (hp) @(negedge a_clk);
    mclk = 1'b0;
  endtask

  task automatic send_frame(input logic [N0-1:0] s, input int nbits, input int pad);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) begin
        logging = 1'b0;
        if (!sel && in_frame) begin
          exp_ferr0++;
          if (exp_ec0 != 16'hFFFF) exp_ec0 = exp_ec0 + 16'd1;
        end
        send_bit(1'b1, s[0]);
        if (!sel) begin
          check("ferr_pulses", 256'(ferr0), 256'(exp_ferr0));
          check("err_count", 256'(error_count0), 256'(exp_ec0));
          check("ds_hold", 256'(dataset_read0), 256'(exp_ds0));
          in_frame = 1'b1;
        end
        txq.delete();
        fsx_n = 0;
        frm_n = 0;
        logging = !sel;
      end else begin
        send_bit(1'b0, s[i[7:0]]);
      end
      if (i == chg_at) tx_dataset = chg_val;
    end
    for (int p = 0; p < pad; p++) send_bit(1'b0, 1'($urandom));
  endtask

  task automatic frame0(input logic [N0-1:0] data, input logic [N0-1:0] txv, input int pad);
    logic [N0-1:0] got_tx;
    tx_dataset = txv;
    send_frame(data, N0, pad);
    in_frame = 1'b0;
    exp_ds0 = data;
    exp_fc0 = exp_fc0 + 32'd1;
    exp_trig0++;
    got_tx = '0;
    for (int i = 0; i < N0 && i < txq.size(); i++) got_tx[i[7:0]] = txq[i];
    check("dataset", 256'(dataset_read0), 256'(exp_ds0));
    check("ds_at_trigger", 256'(ds_at_trig), 256'(exp_ds0));
    check("frame_count", 256'(frame_count0), 256'(exp_fc0));
    check("trig_pulses", 256'(trig0), 256'(exp_trig0));
    check("tx_stream", 256'(got_tx), 256'(txv));
    check("fsx_bits", 256'(fsx_n), 256'(1));
    check("frm_bits", 256'(frm_n), 256'(N0));
  endtask

  function automatic logic [N0-1:0] rand256();
    logic [N0-1:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N0-1:0] d;
    logic [N0-1:0] a_pat;
    logic [N0-1:0] s1;
    logic [N1-1:0] d1;
    int n;

    repeat (3) @(negedge a_clk);
    check("rst_outputs", 256'({tx0, clkr0, fsx0, frm0, trigger0, frame_error0, frame_count0, error_count0}), 256'(0));
    check("rst_dataset", 256'(dataset_read0), 256'(0));
    a_resetn = 1'b1;
    repeat (2) @(negedge a_clk);

    // Clock return lags the external clock by the synchroniser depth plus one.
    mclk = 1'b1;
    n = 0;
    while (!clkr0 && n < 20) begin @(negedge a_clk); n++; end
    check("clkr_lag", 256'(n), 256'(3));
    repeat (hp) @(negedge a_clk);
    mclk = 1'b0;
    repeat (hp) @(negedge a_clk);

    // Basic RX with fixed words, twice, at half-period 12.
    d = '0;
    d[0*32 +: 32] = 32'd13;   d[1*32 +: 32] = 32'd45;
    d[2*32 +: 32] = 32'd77;   d[3*32 +: 32] = 32'd109;
    d[4*32 +: 32] = 32'd141;  d[5*32 +: 32] = 32'd269;
    d[6*32 +: 32] = 32'd525;  d[7*32 +: 32] = 32'd1037;
    frame0(d, rand256(), 10);
    frame0(d, rand256(), 10);
    check("err_zero", 256'(error_count0), 256'(0));
    hp = 6;

    // MSB-first 4x16 instance.
    sel = 1'b1;
    d1 = 64'h0000_FFFF_1234_8001;
    s1 = '0;
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 16; j++)
        s1[8'(w*16 + j)] = d1[6'(w*16 + 15 - j)];
    send_frame(s1, N1, 4);
    check("msb_dataset", 256'(dataset_read1), 256'(64'h0000_FFFF_1234_8001));
    check("msb_trig", 256'(trig1), 256'(1));
    check("msb_fcount", 256'(frame_count1), 256'(1));
    sel = 1'b0;
    repeat (4) @(negedge a_clk);

    // TX loopback: tx_dataset changes mid-frame, pattern A must still come back.
    a_pat = rand256();
    chg_at = 100;
    chg_val = ~a_pat;
    frame0(rand256(), a_pat, 4);
    chg_at = -1;

    // Short frame at bit 100, then a full frame.
    tx_dataset = rand256();
    send_frame(rand256(), 100, 0);
    frame0(rand256(), rand256(), 4);

    // Reset at bit 50.
    send_frame(rand256(), 50, 0);
    a_resetn = 1'b0;
    #1;
    check("midrst_outputs", 256'({tx0, clkr0, fsx0, frm0, trigger0, frame_error0, frame_count0, error_count0}), 256'(0));
    check("midrst_dataset", 256'(dataset_read0), 256'(0));
    repeat (3) @(negedge a_clk);
    a_resetn = 1'b1;
    in_frame = 1'b0;
    exp_ds0 = '0;
    exp_fc0 = 32'd0;
    exp_ec0 = 16'd0;
    repeat (2 * hp) @(negedge a_clk);
    frame0(rand256(), rand256(), 4);
    check("fcount_after_rst", 256'(frame_count0), 256'(1));

    // Error counter saturation and frame counter wrap.
    force dut0.error_count_r = 16'hFFFE;
    @(negedge a_clk);
    release dut0.error_count_r;
    exp_ec0 = 16'hFFFE;
    for (int k = 0; k < 3; k++) send_frame(rand256(), 5, 0);
    force dut0.frame_count_r = 32'hFFFF_FFFF;
    @(negedge a_clk);
    release dut0.frame_count_r;
    exp_fc0 = 32'hFFFF_FFFF;
    frame0(rand256(), rand256(), 4);
    check("err_saturated", 256'(error_count0), 256'(16'hFFFF));
    check("fcount_wrapped", 256'(frame_count0), 256'(0));

    // Random frames with random padding.
    for (int k = 0; k < 3; k++) frame0(rand256(), rand256(), int'($urandom_range(2, 8)));

    check("trig_ferr_overlap", 256'(coincide), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
